// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter, LSB first, with a small byte FIFO in front.
//
// Ports:
//   clk       system clock, single domain
//   rst_n     asynchronous active-low reset
//   we        write strobe; byte taken on rising clk when we && !full
//   wdata     byte to transmit
//   full      FIFO holds FIFO_DEPTH bytes
//   busy      frame in progress or FIFO non-empty
//   overflow  sticky flag: a write was attempted while full (cleared by reset only)
//   tx        serial line, idle high, registered
module uart_tx_fifo #(
    parameter int unsigned WAIT       = 8,  // clocks per bit, >= 2
    parameter int unsigned FIFO_DEPTH = 4   // power of two, >= 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we,
    input  logic [7:0] wdata,
    output logic       full,
    output logic       busy,
    output logic       overflow,
    output logic       tx
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned TW = (WAIT > 1) ? $clog2(WAIT) : 1;

    localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] CNT_LAST   = TW'(WAIT - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic [1:0]    state;
    logic [TW-1:0] cnt;
    logic [2:0]    bitn;
    logic [7:0]    shreg;
    logic          tx_q;
    logic          ovf_q;

    logic push;
    logic pop;
    logic cnt_end;
    logic nonempty;

    assign nonempty = (count != '0);
    assign full     = (count == COUNT_FULL);
    assign cnt_end  = (cnt == CNT_LAST);
    assign push     = we && !full;
    // The FSM takes the head byte when idle, or at the end of a stop bit so frames abut.
    assign pop      = nonempty && ((state == ST_IDLE) || ((state == ST_STOP) && cnt_end));

    assign busy     = (state != ST_IDLE) || nonempty;
    assign overflow = ovf_q;
    assign tx       = tx_q;

    // Storage is not reset; only the pointers and count define valid contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A write while full is dropped even if a pop frees a slot this cycle.
            if (we && full) begin
                ovf_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            bitn  <= '0;
            shreg <= '0;
            tx_q  <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        shreg <= mem[rd_ptr];
                        state <= ST_START;
                        tx_q  <= 1'b0;
                        cnt   <= '0;
                    end
                end
                ST_START: begin
                    if (cnt_end) begin
                        state <= ST_DATA;
                        tx_q  <= shreg[0];
                        bitn  <= '0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt_end) begin
                        cnt <= '0;
                        if (bitn == 3'd7) begin
                            state <= ST_STOP;
                            tx_q  <= 1'b1;
                        end else begin
                            // Next bit is shreg[1] before the shift lands.
                            shreg <= shreg >> 1;
                            tx_q  <= shreg[1];
                            bitn  <= bitn + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (cnt_end) begin
                        cnt <= '0;
                        if (pop) begin
                            shreg <= mem[rd_ptr];
                            state <= ST_START;
                            tx_q  <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                            tx_q  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    tx_q  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized self-checking bench for uart_tx_fifo (WAIT=8, FIFO_DEPTH=4).
// Reference model: each accepted byte is a frame that starts at max(accept+1, previous
// frame end) and lasts 10*WAIT clocks; line level, busy, fullness and overflow are derived
// from that list of frames.
module tb_uart_tx_fifo;

    localparam int W    = 8;
    localparam int D    = 4;
    localparam int FL   = 10 * W;
    localparam int HMAX = 16384;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       we = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic       full;
    logic       busy;
    logic       overflow;
    logic       tx;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .WAIT       (W),
        .FIFO_DEPTH (D)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .wdata    (wdata),
        .full     (full),
        .busy     (busy),
        .overflow (overflow),
        .tx       (tx)
    );

    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;

    int         acc_a[$];   // edge at which byte was accepted
    int         acc_s[$];   // edge at which its start bit is driven
    logic [7:0] acc_d[$];
    logic       ovf_m = 1'b0;

    logic       tx_hist[HMAX];
    logic       busy_hist[HMAX];
    logic [7:0] rx_q[$];

    function automatic int fifo_level(input int t);
        int n = 0;
        foreach (acc_a[i]) if (acc_a[i] <= t && acc_s[i] > t) n++;
        return n;
    endfunction

    function automatic logic model_tx(input int t);
        foreach (acc_s[i]) begin
            if (t >= acc_s[i] && t < acc_s[i] + FL) begin
                int         ph = (t - acc_s[i]) / W;
                logic [7:0] b  = acc_d[i];
                if (ph == 0) return 1'b0;
                if (ph == 9) return 1'b1;
                return b[3'(ph - 1)];
            end
        end
        return 1'b1;
    endfunction

    function automatic logic model_busy(input int t);
        foreach (acc_a[i]) if (acc_a[i] <= t && t < acc_s[i] + FL) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] model_vec(input int t);
        return {model_tx(t), model_busy(t), fifo_level(t) == D, ovf_m};
    endfunction

    function automatic void model_clear();
        acc_a.delete();
        acc_s.delete();
        acc_d.delete();
        ovf_m = 1'b0;
    endfunction

    // One clock: drive inputs, take the edge, update the model, sample #1 later.
    task automatic tick(input logic w, input logic [7:0] d);
        int s;
        we = w;
        wdata = d;
        @(posedge clk);
        cyc++;
        if (rst_n && w) begin
            if (fifo_level(cyc - 1) < D) begin
                s = cyc + 1;
                if (acc_s.size() > 0 && acc_s[acc_s.size() - 1] + FL > s)
                    s = acc_s[acc_s.size() - 1] + FL;
                acc_a.push_back(cyc);
                acc_s.push_back(s);
                acc_d.push_back(d);
            end else begin
                ovf_m = 1'b1;
            end
        end
        #1;
        tx_hist[cyc] = tx;
        busy_hist[cyc] = busy;
        we = 1'b0;
        wdata = 8'($urandom);
    endtask

    // Recover bytes from the recorded line by mid-bit sampling.
    task automatic decode(input int from, input int to);
        int         t;
        logic [7:0] b;
        rx_q.delete();
        t = from;
        while (t + FL <= to) begin
            if (tx_hist[t - 1] === 1'b1 && tx_hist[t] === 1'b0) begin
                for (int k = 0; k < 8; k++) b[k] = tx_hist[t + W * (k + 1) + W / 2];
                rx_q.push_back(b);
                t = t + FL;
            end else begin
                t++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick(1'b0, 8'h00);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 8'h00);
            tests++;
            if ({tx, busy, full, overflow} !== 4'b1000) begin
                fails++;
                $display("FAIL reset_idle cyc=%0d got=%b exp=1000", cyc, {tx, busy, full, overflow});
            end
        end
    endtask

    task automatic test_single();
        int n;
        tick(1'b1, 8'h55);
        n = cyc;
        for (int i = 0; i < 90; i++) begin
            tick(1'b0, 8'h00);
            tests++;
            if ({tx, busy, full, overflow} !== model_vec(cyc)) begin
                fails++;
                $display("FAIL single_line cyc=%0d got=%b exp=%b", cyc,
                         {tx, busy, full, overflow}, model_vec(cyc));
            end
        end
        tests++;
        if (tx_hist[n] !== 1'b1 || tx_hist[n + 1] !== 1'b0) begin
            fails++;
            $display("FAIL single_latency got=%b%b exp=10", tx_hist[n], tx_hist[n + 1]);
        end
        tests++;
        if (busy_hist[n + 80] !== 1'b1 || busy_hist[n + 81] !== 1'b0) begin
            fails++;
            $display("FAIL single_busy_end got=%b%b exp=10", busy_hist[n + 80], busy_hist[n + 81]);
        end
        decode(n + 1, cyc);
        tests++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h55) begin
            fails++;
            $display("FAIL single_decode got_n=%0d exp_n=1", rx_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes[4];
        int         n;
        int         drop;
        bytes[0] = 8'hA5; bytes[1] = 8'h3C; bytes[2] = 8'hFF; bytes[3] = 8'h00;
        n = cyc + 1;
        for (int i = 0; i < 4; i++) tick(1'b1, bytes[i]);
        for (int i = 0; i < 4 * FL + 10; i++) begin
            tick(1'b0, 8'h00);
            tests++;
            if ({tx, busy, full, overflow} !== model_vec(cyc)) begin
                fails++;
                $display("FAIL b2b_line cyc=%0d got=%b exp=%b", cyc,
                         {tx, busy, full, overflow}, model_vec(cyc));
            end
        end
        drop = 0;
        for (int t = n; t <= cyc; t++) if (drop == 0 && busy_hist[t] === 1'b0) drop = t;
        tests++;
        if (drop != n + 1 + 4 * FL) begin
            fails++;
            $display("FAIL b2b_span got=%0d exp=%0d", drop - n, 1 + 4 * FL);
        end
        decode(n + 1, cyc);
        tests++;
        if (rx_q.size() != 4) begin
            fails++;
            $display("FAIL b2b_count got=%0d exp=4", rx_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (rx_q[i] !== bytes[i]) begin
                    fails++;
                    $display("FAIL b2b_byte%0d got=%h exp=%h", i, rx_q[i], bytes[i]);
                end
            end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] bytes[6];
        int         n;
        n = cyc + 1;
        for (int i = 0; i < 6; i++) begin
            bytes[i] = 8'($urandom);
            tick(1'b1, bytes[i]);
            if (i == 4) begin
                tests++;
                if (full !== 1'b1 || overflow !== 1'b0) begin
                    fails++;
                    $display("FAIL ovf_full got=%b%b exp=10", full, overflow);
                end
            end
        end
        tests++;
        if (overflow !== 1'b1) begin
            fails++;
            $display("FAIL ovf_flag got=%b exp=1", overflow);
        end
        for (int i = 0; i < 5 * FL + 20; i++) begin
            tick(1'b0, 8'h00);
            tests++;
            if ({tx, busy, full, overflow} !== model_vec(cyc)) begin
                fails++;
                $display("FAIL ovf_line cyc=%0d got=%b exp=%b", cyc,
                         {tx, busy, full, overflow}, model_vec(cyc));
            end
        end
        decode(n + 1, cyc);
        tests++;
        if (rx_q.size() != 5) begin
            fails++;
            $display("FAIL ovf_frames got=%0d exp=5", rx_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                tests++;
                if (rx_q[i] !== bytes[i]) begin
                    fails++;
                    $display("FAIL ovf_byte%0d got=%h exp=%h", i, rx_q[i], bytes[i]);
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        int s;
        tick(1'b1, 8'h81);
        s = cyc + 1;
        tick(1'b1, 8'($urandom));
        tick(1'b1, 8'($urandom));
        while (cyc < s + 4 * W + 3) begin
            tick(1'b0, 8'h00);
            tests++;
            if ({tx, busy, full, overflow} !== model_vec(cyc)) begin
                fails++;
                $display("FAIL mid_line cyc=%0d got=%b exp=%b", cyc,
                         {tx, busy, full, overflow}, model_vec(cyc));
            end
        end
        #2 rst_n = 1'b0;
        model_clear();
        #1;
        tests++;
        if (tx !== 1'b1 || busy !== 1'b0 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL mid_async got=%b%b%b exp=100", tx, busy, overflow);
        end
        repeat (2) tick(1'b0, 8'h00);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick(1'b0, 8'h00);
            tests++;
            if ({tx, busy, full, overflow} !== 4'b1000) begin
                fails++;
                $display("FAIL mid_after cyc=%0d got=%b exp=1000", cyc, {tx, busy, full, overflow});
            end
        end
    endtask

    task automatic test_stop_boundary();
        int e;
        tick(1'b1, 8'($urandom));
        e = acc_s[acc_s.size() - 1] + FL;
        while (cyc < e - 1) begin
            tick(1'b0, 8'h00);
            tests++;
            if ({tx, busy, full, overflow} !== model_vec(cyc)) begin
                fails++;
                $display("FAIL stop_line cyc=%0d got=%b exp=%b", cyc,
                         {tx, busy, full, overflow}, model_vec(cyc));
            end
        end
        tick(1'b1, 8'($urandom));
        for (int i = 0; i < 100; i++) begin
            tick(1'b0, 8'h00);
            tests++;
            if ({tx, busy, full, overflow} !== model_vec(cyc)) begin
                fails++;
                $display("FAIL stop_line cyc=%0d got=%b exp=%b", cyc,
                         {tx, busy, full, overflow}, model_vec(cyc));
            end
        end
        tests++;
        if (tx_hist[e] !== 1'b1 || tx_hist[e + 1] !== 1'b0 || busy_hist[e] !== 1'b1) begin
            fails++;
            $display("FAIL stop_restart got=%b%b%b exp=101", tx_hist[e], tx_hist[e + 1],
                     busy_hist[e]);
        end
    endtask

    task automatic test_random();
        int first;
        int start;
        start = cyc + 1;
        first = acc_d.size();
        for (int i = 0; i < 800 + 5 * FL + 20; i++) begin
            if (i < 800 && $urandom_range(0, 999) < 20) tick(1'b1, 8'($urandom));
            else tick(1'b0, 8'($urandom));
            tests++;
            if ({tx, busy, full, overflow} !== model_vec(cyc)) begin
                fails++;
                $display("FAIL rand_line cyc=%0d got=%b exp=%b", cyc,
                         {tx, busy, full, overflow}, model_vec(cyc));
            end
        end
        decode(start, cyc);
        tests++;
        if (rx_q.size() != acc_d.size() - first) begin
            fails++;
            $display("FAIL rand_frames got=%0d exp=%0d", rx_q.size(), acc_d.size() - first);
        end else begin
            foreach (rx_q[i]) begin
                tests++;
                if (rx_q[i] !== acc_d[first + i]) begin
                    fails++;
                    $display("FAIL rand_byte%0d got=%h exp=%h", i, rx_q[i], acc_d[first + i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_reset_midframe();
        test_stop_boundary();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
